nrisc_mc_core: RTL

Multi-cycle, parametrised successor to the single-cycle nRisc core. It keeps the 8-bit nRisc instruction encoding and generalises datapath width and PC width. It adds req/ack handshakes on separate instruction and data memory ports, so memories with variable latency can be used. It sits between the instruction ROM and the data RAM wrappers in the top level, in place of the single-cycle core.

---
 rtl/nrisc_pkg.sv | 39 +++
 rtl/nrisc_regfile.sv | 36 +++
 rtl/nrisc_mc_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants for the multi-cycle nRisc core.
// Opcodes, FSM state codes, ALU operation codes and register indices.
package nrisc_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_LOGIC = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] R3_IDX = 2'd3;

    // Map opcode and function bit to the ALU operation.
    function automatic logic [1:0] alu_sel(input logic [2:0] op, input logic f);
        logic [1:0] sel;
        sel = ALU_ADD;
        if (op == OP_ALU)
            sel = f ? ALU_SUB : ALU_ADD;
        else if (op == OP_LOGIC)
            sel = f ? ALU_OR : ALU_AND;
        return sel;
    endfunction

endpackage

// File: rtl/nrisc_regfile.sv
// nrisc_regfile: 4-entry register file, two combinational read ports,
// a dedicated R3 read port and one synchronous write port.
module nrisc_regfile
    import nrisc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ra,
    input  logic [1:0]        rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] r3,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [4];

    assign rdata_a = regs[ra];
    assign rdata_b = regs[rb];
    assign r3      = regs[R3_IDX];

    // Synchronous clear on reset, otherwise single-port write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/nrisc_mc_core.sv
// nrisc_mc_core: multi-cycle nRisc core with req/ack memory ports.
// Define NRISC_TRACE_EN to add the retire_valid/retire_pc/retire_ir ports.
module nrisc_mc_core
    import nrisc_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter int              PC_W    = 8,
    parameter logic [PC_W-1:0] HALT_PC = {PC_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [PC_W-1:0]   pc_out
`ifdef NRISC_TRACE_EN
    ,
    output logic              retire_valid,
    output logic [PC_W-1:0]   retire_pc,
    output logic [7:0]        retire_ir
`endif
);

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] mdr;
    logic              run;

    logic [2:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic              f;
    logic [DATA_W-1:0] imm2;
    logic [DATA_W-1:0] imm5;

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] rf_r3;
    logic              rf_we;
    logic [1:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_y;
    logic [PC_W-1:0]   npc_c;
    logic              is_mem;

    assign op   = ir[7:5];
    assign rd   = ir[4:3];
    assign rs   = ir[2:1];
    assign f    = ir[0];
    assign imm2 = DATA_W'(rs);
    assign imm5 = DATA_W'(ir[4:0]);

    assign is_mem = (op == OP_LW) || (op == OP_SW);

    nrisc_regfile #(
        .DATA_W(DATA_W)
    ) u_rf (
        .clk    (CLK),
        .rst_n  (RST_N),
        .ra     (rd),
        .rb     (rs),
        .rdata_a(rf_a),
        .rdata_b(rf_b),
        .r3     (rf_r3),
        .we     (rf_we),
        .wa     (rf_wa),
        .wd     (rf_wd)
    );

    // ALU: ADDI reuses the adder with an optional zeroed first operand.
    always_comb begin
        opa = a;
        opb = b;
        if (op == OP_ADDI) begin
            opa = f ? a : '0;
            opb = imm2;
        end
        case (alu_sel(op, f))
            ALU_ADD: alu_y = opa + opb;
            ALU_SUB: alu_y = opa - opb;
            ALU_AND: alu_y = opa & opb;
            ALU_OR:  alu_y = opa | opb;
            default: alu_y = opa + opb;
        endcase
    end

    // Next PC: branch/jump targets come from the R3 snapshot taken in DECODE.
    always_comb begin
        npc_c = pc + PC_W'(1);
        if (op == OP_JMP)
            npc_c = PC_W'(c);
        else if (op == OP_BEQ && a == b)
            npc_c = PC_W'(c);
    end

    // Write-back port: loads target R3, everything else targets rd.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd;
        rf_wd = res;
        if (state == ST_WB) begin
            rf_we = (op == OP_ALU) || (op == OP_ADDI) ||
                    (op == OP_LOGIC) || (op == OP_LW);
        end
        if (op == OP_LW) begin
            rf_wa = R3_IDX;
            rf_wd = mdr;
        end
    end

    // Main FSM; run holds fetch requests off for the cycle after reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_FETCH;
            pc    <= '0;
            npc   <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            res   <= '0;
            mdr   <= '0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a     <= rf_a;
                    b     <= rf_b;
                    c     <= rf_r3;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res   <= alu_y;
                    npc   <= npc_c;
                    state <= is_mem ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LW)
                            mdr <= dmem_rdata;
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (op == OP_HALT && f) begin
                        pc    <= HALT_PC;
                        state <= ST_HALT;
                    end else begin
                        pc    <= npc;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign imem_req   = (state == ST_FETCH) && run;
    assign imem_addr  = pc;
    assign dmem_req   = (state == ST_MEM);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign dmem_addr  = dmem_req ? imm5 : '0;
    assign dmem_wdata = dmem_we ? c : '0;
    assign halted     = (state == ST_HALT);
    assign pc_out     = pc;

`ifdef NRISC_TRACE_EN
    assign retire_valid = (state == ST_WB);
    assign retire_pc    = pc;
    assign retire_ir    = ir;
`endif

endmodule
